hc_rd_scheduler: RTL and testbench

Sequences CCI-P c0 read requests over the host buffers programmed through the HardCloud buffer CSRs (address/size pairs). On start it walks buffers 0..NUM_BUFS-1 in order, one cache line per request, honouring c0TxAlmFull and an outstanding-request cap. It counts read responses and flags completion to the control FSM that drives the Smith-Waterman read/write pipelines.

---
 rtl/hc_rd_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_hc_rd_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_rd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | hc_rd_scheduler: walks HardCloud buffer descriptors and issues CCI-P c0  |
// | line reads under c0TxAlmFull and an in-flight cap, counting responses.   |
// | Optional macro HC_RD_PERF_CNT_EN enables perf_cycles/perf_stall counters.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hc_rd_scheduler #(
  parameter int NUM_BUFS        = 2,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [64*NUM_BUFS-1:0]   buf_addr,
  input  logic [32*NUM_BUFS-1:0]   buf_size,
  input  logic                     tx_almfull,
  output logic                     rd_req_valid,
  output logic [41:0]              rd_req_addr,
  output logic [15:0]              rd_req_mdata,
  input  logic                     rd_rsp_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     err_unexp_rsp,
  output logic [8:0]               outstanding,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stall
);

  localparam logic [8:0] C_MAX_OUT  = 9'(MAX_OUTSTANDING);
  localparam logic [2:0] C_LAST_BUF = 3'(NUM_BUFS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_buf_idx;
  logic [41:0] r_base;
  logic [26:0] r_lines;
  logic [26:0] r_line_idx;
  logic [8:0]  r_outstanding;
  logic        r_aborted;
  logic        r_err;

  logic [63:0] w_sel_addr;
  logic [31:0] w_sel_size;
  logic [32:0] w_size_rnd;
  logic [26:0] w_sel_lines;
  logic        w_issue;
  logic        w_last_line;
  logic        w_last_buf;
  logic        w_start_acc;
  logic        w_unused;

  always_comb begin
    w_sel_addr = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (r_buf_idx == 3'(i)) begin
        w_sel_addr = buf_addr[64*i +: 64];
        w_sel_size = buf_size[32*i +: 32];
      end
    end
  end

  // Round the byte size up to whole 64B lines.
  assign w_size_rnd  = {1'b0, w_sel_size} + 33'd63;
  assign w_sel_lines = w_size_rnd[32:6];
  assign w_unused    = ^{w_sel_addr[63:48], w_sel_addr[5:0], w_size_rnd[5:0]};

  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue     = (r_state == S_ISSUE) && !tx_almfull &&
                       (r_outstanding < C_MAX_OUT) && !stop;
  assign w_last_line = ((r_line_idx + 27'd1) == r_lines);
  assign w_last_buf  = (r_buf_idx == C_LAST_BUF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (stop)                     w_state_nxt = S_DRAIN;
        else if (w_sel_lines != '0)   w_state_nxt = S_ISSUE;
        else if (w_last_buf)          w_state_nxt = S_DRAIN;
      end
      S_ISSUE: begin
        if (stop)                         w_state_nxt = S_DRAIN;
        else if (w_issue && w_last_line)  w_state_nxt = w_last_buf ? S_DRAIN : S_LOAD;
      end
      S_DRAIN: begin
        if (r_outstanding == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_idx  <= '0;
      r_base     <= '0;
      r_lines    <= '0;
      r_line_idx <= '0;
      r_aborted  <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_buf_idx <= '0;
        r_aborted <= 1'b0;
      end else if (r_state == S_LOAD) begin
        if (stop) begin
          r_aborted <= 1'b1;
        end else if (w_sel_lines == '0) begin
          r_buf_idx <= r_buf_idx + 3'd1;
        end else begin
          r_base     <= w_sel_addr[47:6];
          r_lines    <= w_sel_lines;
          r_line_idx <= '0;
        end
      end else if (r_state == S_ISSUE) begin
        if (stop) begin
          r_aborted <= 1'b1;
        end else if (w_issue) begin
          r_line_idx <= r_line_idx + 27'd1;
          if (w_last_line) r_buf_idx <= r_buf_idx + 3'd1;
        end
      end
    end
  end

  // An issue and a response in the same cycle cancel; a response with
  // nothing in flight is flagged rather than allowed to underflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_issue && !rd_rsp_valid) begin
        r_outstanding <= r_outstanding + 9'd1;
      end else if (!w_issue && rd_rsp_valid) begin
        if (r_outstanding != '0) r_outstanding <= r_outstanding - 9'd1;
      end
      if (w_start_acc)
        r_err <= 1'b0;
      else if (rd_rsp_valid && !w_issue && (r_outstanding == '0))
        r_err <= 1'b1;
    end
  end

  assign rd_req_valid  = w_issue;
  assign rd_req_addr   = w_issue ? (r_base + {15'd0, r_line_idx}) : '0;
  assign rd_req_mdata  = w_issue ? {r_buf_idx, r_line_idx[12:0]} : '0;
  assign busy          = (r_state == S_LOAD) || (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign aborted       = r_aborted;
  assign err_unexp_rsp = r_err;
  assign outstanding   = r_outstanding;

`ifdef HC_RD_PERF_CNT_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_start_acc) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_ISSUE) && (tx_almfull || (r_outstanding >= C_MAX_OUT)) &&
          (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`else
  assign perf_cycles = '0;
  assign perf_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hc_rd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hc_rd_scheduler: directed bench with a request-list/in-flight model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hc_rd_scheduler;
  localparam int NB   = 2;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tx_almfull = 1'b0;
  logic          rd_rsp_valid = 1'b0;
  logic [127:0]  buf_addr = '0;
  logic [63:0]   buf_size = '0;
  logic          rd_req_valid;
  logic [41:0]   rd_req_addr;
  logic [15:0]   rd_req_mdata;
  logic          busy, done, aborted, err_unexp_rsp;
  logic [8:0]    outstanding;
  logic [31:0]   perf_cycles, perf_stall;

  hc_rd_scheduler #(.NUM_BUFS(NB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .buf_addr(buf_addr), .buf_size(buf_size), .tx_almfull(tx_almfull),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_rsp_valid(rd_rsp_valid), .busy(busy), .done(done), .aborted(aborted),
    .err_unexp_rsp(err_unexp_rsp), .outstanding(outstanding),
    .perf_cycles(perf_cycles), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [41:0] a; logic [15:0] m; } req_t;
  req_t        exp_q[$];
  logic [41:0] obs_a[$];
  logic [15:0] obs_m[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_out = 0;
  int          pend_auto = 0;
  int          man_rsp = 0;
  bit          auto_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected request list straight from the descriptors: buffers in order,
  // one request per 64B line (size rounded up).
  task automatic build_exp();
    req_t        r;
    longint      lines;
    logic [63:0] a;
    logic [31:0] s;
    logic [2:0]  bb;
    logic [12:0] ll;
    exp_q.delete();
    obs_a.delete();
    obs_m.delete();
    for (int b = 0; b < NB; b++) begin
      a = buf_addr[64*b +: 64];
      s = buf_size[32*b +: 32];
      lines = (longint'(s) + 63) / 64;
      for (longint l = 0; l < lines; l++) begin
        bb  = 3'(b);
        ll  = 13'(l);
        r.a = 42'((a >> 6) + 64'(l));
        r.m = {bb, ll};
        exp_q.push_back(r);
      end
    end
  endtask

  // Compare process: in-flight model plus ordered request scoreboard.
  always @(negedge clk) begin : cmp
    req_t h;
    if (!reset_n) begin
      check("reset_outputs",
            {rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, aborted, err_unexp_rsp},
            64'd0);
      check("reset_outstanding", 64'(outstanding), 64'd0);
      m_out = 0;
    end else begin
      check("outstanding", 64'(outstanding), 64'(m_out));
      if (rd_req_valid) begin
        check("req_while_blocked", 64'(tx_almfull || stop || (m_out >= MAXO)), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL req_unexpected: got addr 0x%0h mdata 0x%0h expected no request",
                   rd_req_addr, rd_req_mdata);
        end else begin
          h = exp_q.pop_front();
          check("req_addr", 64'(rd_req_addr), 64'(h.a));
          check("req_mdata", 64'(rd_req_mdata), 64'(h.m));
        end
        obs_a.push_back(rd_req_addr);
        obs_m.push_back(rd_req_mdata);
        if (auto_rsp) pend_auto++;
        m_out++;
      end
      if (rd_rsp_valid && m_out > 0) m_out--;
    end
  end

  always @(posedge clk) begin
    #2;
    if (reset_n && pend_auto > 0) begin
      rd_rsp_valid = 1'b1;
      pend_auto--;
    end else if (reset_n && man_rsp > 0) begin
      rd_rsp_valid = 1'b1;
      man_rsp--;
    end else begin
      rd_rsp_valid = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit with_stop);
    cyc(1);
    build_exp();
    start = 1'b1;
    stop  = with_stop;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      cyc(1);
    end
    check("done_reached", 64'(done), 64'd1);
    check("done_not_busy", 64'(busy), 64'd0);
    check("done_outstanding", 64'(outstanding), 64'd0);
    check("all_lines_issued", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (obs_a.size() >= n) break;
      cyc(1);
    end
    check("reached_req_count", 64'(obs_a.size()), 64'(n));
  endtask

  initial begin
    int n0;
    buf_addr = {64'h8000, 64'h1000};
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    // Two buffers, immediate responses; a stop alongside start is ignored.
    buf_size = {32'd64, 32'd128};
    auto_rsp = 1'b1;
    start_run(1'b1);
    wait_done(200);
    check("t1_count", 64'(obs_a.size()), 64'd3);
    check("t1_addr0", 64'(obs_a[0]), 64'h40);
    check("t1_addr1", 64'(obs_a[1]), 64'h41);
    check("t1_addr2", 64'(obs_a[2]), 64'h200);
    check("t1_mdata0", 64'(obs_m[0]), 64'h0000);
    check("t1_mdata1", 64'(obs_m[1]), 64'h0001);
    check("t1_mdata2", 64'(obs_m[2]), 64'h2000);
    check("t1_not_aborted", 64'(aborted), 64'd0);

    // Empty first buffer is skipped.
    buf_size = {32'd100, 32'd0};
    start_run(1'b0);
    wait_done(200);
    check("t2_count", 64'(obs_a.size()), 64'd2);
    check("t2_addr1", 64'(obs_a[1]), 64'h201);
    check("t2_mdata1", 64'(obs_m[1]), 64'h2001);

    // Outstanding cap: no responses, 4 issued then stall.
    buf_size = {32'd0, 32'd640};
    auto_rsp = 1'b0;
    start_run(1'b0);
    cyc(12);
    check("t3_capped_count", 64'(obs_a.size()), 64'd4);
    check("t3_capped_outstanding", 64'(outstanding), 64'd4);
`ifdef HC_RD_PERF_CNT_EN
    check("t3_perf_stall_nonzero", 64'(perf_stall != 0), 64'd1);
`endif
    man_rsp = 1;
    cyc(2);
    check("t3_fifth_after_release", 64'(obs_a.size()), 64'd5);
    check("t3_fifth_addr", 64'(obs_a[4]), 64'h44);
    cyc(5);
    check("t3_recapped", 64'(obs_a.size()), 64'd5);
    man_rsp  = 4;
    auto_rsp = 1'b1;
    wait_done(300);
    check("t3_total", 64'(obs_a.size()), 64'd10);

    // tx_almfull window mid-run.
    buf_size = {32'd64, 32'd640};
    start_run(1'b0);
    wait_obs(3, 50);
    tx_almfull = 1'b1;
    n0 = obs_a.size();
    cyc(10);
    check("t4_no_req_almfull", 64'(obs_a.size()), 64'(n0));
    tx_almfull = 1'b0;
    wait_done(300);
    check("t4_total", 64'(obs_a.size()), 64'd11);

    // Stop after 3 issued requests.
    buf_size = {32'd0, 32'd640};
    auto_rsp = 1'b0;
    start_run(1'b0);
    wait_obs(3, 50);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    exp_q.delete();
    check("t5_aborted", 64'(aborted), 64'd1);
    check("t5_draining_busy", 64'(busy), 64'd1);
    cyc(5);
    check("t5_no_more_req", 64'(obs_a.size()), 64'd3);
    check("t5_not_done_yet", 64'(done), 64'd0);
    man_rsp = 3;
    wait_done(100);
    check("t5_aborted_held", 64'(aborted), 64'd1);

    // Unexpected response and stop while done.
    man_rsp = 1;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(3);
    check("t6_err_set", 64'(err_unexp_rsp), 64'd1);
    check("t6_outstanding_zero", 64'(outstanding), 64'd0);
    check("t6_done_held", 64'(done), 64'd1);

    // Restart clears sticky flags.
    buf_size = {32'd0, 32'd64};
    auto_rsp = 1'b1;
    start_run(1'b0);
    check("t7_err_cleared", 64'(err_unexp_rsp), 64'd0);
    check("t7_aborted_cleared", 64'(aborted), 64'd0);
    wait_done(100);
    check("t7_addr0", 64'(obs_a[0]), 64'h40);

    // Asynchronous reset mid-run.
    buf_size = {32'd0, 32'd640};
    auto_rsp = 1'b0;
    start_run(1'b0);
    wait_obs(2, 50);
    reset_n = 1'b0;
    #1;
    check("t8_async_reset_outputs",
          {rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, aborted, err_unexp_rsp},
          64'd0);
    check("t8_async_reset_outstanding", 64'(outstanding), 64'd0);
    exp_q.delete();
    pend_auto = 0;
    man_rsp   = 0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    check("t8_idle_after_reset", 64'({busy, done}), 64'd0);

`ifndef HC_RD_PERF_CNT_EN
    check("perf_cycles_tied", 64'(perf_cycles), 64'd0);
    check("perf_stall_tied", 64'(perf_stall), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
